burst_error_scheduler: RTL and testbench
========================================

# burst_error_scheduler

Frame-level controller that sequences burst error injection into the Hamming test channel. Accepts 128-bit codewords over a valid/ready handshake, decides per frame whether to corrupt it, computes the 16 flip positions for the combinational burst error generator, and presents the registered corrupted frame downstream. Sits between the Hamming encoder output and the decoder input in the test harness.

## Interface
- DATA_W, 128, frame width; positions are taken mod DATA_W
- POS_W, 8, width of one error position; value 8'h80 means "no flip"
- MAX_BURST, 16, number of error slots
- LFSR_SEED, 16'hACE1, reset value of start-position LFSR
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  write strobe for all cfg_* fields
- cfg_burst_len  in  5  burst length 0..31; values >16 clamp to 16
- cfg_period  in  8  inject into every Nth accepted frame; 0 disables injection
- cfg_mode  in  1  0 = fixed start (cfg_start), 1 = LFSR start
- cfg_start  in  7  fixed burst start bit index
- in_valid  in  1  input frame valid
- in_ready  out  1  scheduler can accept a frame
- in_data  in  128  input codeword
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts
- out_data  out  128  possibly corrupted codeword
- out_injected  out  1  out_data carries a burst
- out_start  out  7  start index used for the current output frame
- frames_injected  out  16  saturating count of corrupted frames

## Operation
- Config: cfg_we latches all cfg_* into shadow registers and clears period counter; applies from the next accepted frame.
- Accept: frame accepted when in_valid && in_ready.
- Period counter pcnt (8 bit): on each accept, if shadow period==0 no injection, pcnt holds 0; else inject when pcnt==period-1, then pcnt←0, otherwise pcnt←pcnt+1.
- Start: mode 0 → cfg_start; mode 1 → lfsr[6:0]. LFSR 16-bit Fibonacci, taps 16,14,13,11; advances only on injected frames, after its value is used.
- Slot i (0..15): position (start+i) mod 128 if inject && i<len_eff, else 8'h80. len_eff = min(burst_len,16). Wraps past bit 127 to bit 0; positions are distinct, so no double flip.
- Non-injected frames pass unchanged (all slots 8'h80).
- frames_injected increments on each injected accept, saturates at 16'hFFFF.
- Output stage: states EMPTY, FULL. EMPTY --accept--> FULL. FULL & out_ready & !accept --> EMPTY. FULL & out_ready & accept --> FULL (new data). FULL & !out_ready holds data stable.
- in_ready = (state==EMPTY) || out_ready.
- cfg_we concurrent with accept: the frame uses old shadow config; pcnt cleared to 0 regardless.

## Timing
- Latency input accept → out_valid: 1 cycle. Throughput 1 frame/cycle with out_ready held high.
- out_data, out_injected, out_start stable while out_valid && !out_ready.
- Reset values: in_ready 1, out_valid 0, out_data 0, out_injected 0, out_start 0, frames_injected 0; pcnt 0, lfsr LFSR_SEED, shadow config all 0 (injection disabled).
- Reset mid-frame: held output frame discarded, no partial output.

## Structure
- Shared package hamming_pkg: DATA_W, POS_W, MAX_BURST, NO_ERR_POS (8'h80), LFSR taps/seed.
- One sub-module: burst_error_generator instantiated with the 16 computed slots; everything else (config, counter, LFSR, output register) in this module.

## Test plan
- Reset, no cfg: stream 4 frames 128'h1234… → identical on out, out_injected 0, latency 1 cycle.
- cfg period=1, len=4, mode 0, start=10, in_data 0 → out_data bits 10..13 set, frames_injected 1.
- start=126, len=4, in_data 0 → bits 126,127,0,1 set (wrap).
- period=3, 6 frames of all-ones → frames 3 and 6 corrupted only; len=20 → exactly 16 bits cleared.
- mode 1, period=1: first start = 16'hACE1[6:0] = 7'h61, second matches next LFSR state.
- out_ready low 5 cycles with in_valid high: in_ready low, out_data stable, no frame lost; assert rst_n mid-hold → out_valid 0 asynchronously.

Source files
------------

// File: rtl/hamming_pkg.sv
// Constants and types shared by the Hamming test-channel blocks:
// frame geometry, the "no flip" position code, and the start-position LFSR.
package hamming_pkg;

  localparam int DATA_W    = 128;
  localparam int POS_W     = 8;
  localparam int IDX_W     = 7;
  localparam int MAX_BURST = 16;

  localparam logic [POS_W-1:0] NO_ERR_POS = 8'h80;
  localparam logic [15:0]      LFSR_SEED  = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0]      LFSR_TAPS  = 16'h002D;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {fb, cur[15:1]};
  endfunction

endpackage

// File: rtl/burst_error_scheduler_if.sv
// Frame stream into and out of the burst error scheduler.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// sender holds valid and its payload stable until that edge, and ready may
// depend combinationally on the downstream ready but never on valid.
interface burst_error_scheduler_if;
  import hamming_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_injected;
  logic [IDX_W-1:0]  out_start;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_injected, out_start
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_injected, out_start
  );

endinterface

// File: rtl/burst_error_generator.sv
// Combinational burst error generator: flips every bit named by a slot whose
// position is in range; out-of-range codes (NO_ERR_POS) leave the frame alone.
module burst_error_generator
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0]          data_in,
  input  pos_t [MAX_BURST-1:0]       pos,
  output logic [DATA_W-1:0]          data_out
);

  logic [DATA_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_BURST; i++) begin
      if (pos[i] < POS_W'(DATA_W)) begin
        mask[pos[i][IDX_W-1:0]] = 1'b1;
      end
    end
  end

  assign data_out = data_in ^ mask;

endmodule

// File: rtl/burst_error_scheduler.sv
// Frame-level burst error scheduler: decides per accepted frame whether to
// corrupt it, builds the burst slots, and registers the result downstream.
module burst_error_scheduler
  import hamming_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_burst_len,
  input  logic [7:0]           cfg_period,
  input  logic                 cfg_mode,
  input  logic [IDX_W-1:0]     cfg_start,
  burst_error_scheduler_if.slave bus,
  output logic [15:0]          frames_injected,
  output out_state_e           dbg_state
);

  logic [4:0]        sh_len;
  logic [7:0]        sh_period;
  logic              sh_mode;
  logic [IDX_W-1:0]  sh_start;

  logic [7:0]        pcnt;
  logic [15:0]       lfsr;

  out_state_e        state, state_nxt;
  logic              in_ready_c;
  logic              accept;

  logic              inject_c;
  logic [IDX_W-1:0]  start_c;
  logic [4:0]        len_eff;
  pos_t [MAX_BURST-1:0] slots;
  logic [DATA_W-1:0] gen_out;

  logic [DATA_W-1:0] out_data_q;
  logic              out_inj_q;
  logic [IDX_W-1:0]  out_start_q;

  assign accept    = bus.in_valid && in_ready_c;
  assign inject_c  = (sh_period != 8'd0) && (pcnt == sh_period - 8'd1);
  assign start_c   = sh_mode ? lfsr[IDX_W-1:0] : sh_start;
  assign len_eff   = (sh_len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : sh_len;

  // Consecutive 7-bit positions wrap naturally past bit 127 back to bit 0.
  always_comb begin
    for (int i = 0; i < MAX_BURST; i++) begin
      slots[i] = NO_ERR_POS;
      if (inject_c && (5'(i) < len_eff)) begin
        slots[i] = {{(POS_W-IDX_W){1'b0}}, start_c + IDX_W'(i)};
      end
    end
  end

  burst_error_generator u_gen (
    .data_in  (bus.in_data),
    .pos      (slots),
    .data_out (gen_out)
  );

  // Shadow configuration; a write always restarts the period count, even if a
  // frame is accepted in the same cycle (that frame still sees the old config).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_len    <= '0;
      sh_period <= '0;
      sh_mode   <= 1'b0;
      sh_start  <= '0;
      pcnt      <= '0;
    end else begin
      if (cfg_we) begin
        sh_len    <= cfg_burst_len;
        sh_period <= cfg_period;
        sh_mode   <= cfg_mode;
        sh_start  <= cfg_start;
        pcnt      <= '0;
      end else if (accept) begin
        if (sh_period == 8'd0 || inject_c) begin
          pcnt <= '0;
        end else begin
          pcnt <= pcnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr            <= LFSR_SEED;
      frames_injected <= '0;
    end else if (accept && inject_c) begin
      lfsr <= lfsr_next(lfsr);
      if (frames_injected != 16'hFFFF) begin
        frames_injected <= frames_injected + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OUT_EMPTY;
      out_data_q  <= '0;
      out_inj_q   <= 1'b0;
      out_start_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data_q  <= gen_out;
        out_inj_q   <= inject_c;
        out_start_q <= inject_c ? start_c : '0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = (state == OUT_EMPTY) || bus.out_ready;
    case (state)
      OUT_EMPTY: if (accept) state_nxt = OUT_FULL;
      OUT_FULL:  if (bus.out_ready && !accept) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (state == OUT_FULL);
  assign bus.out_data     = out_data_q;
  assign bus.out_injected = out_inj_q;
  assign bus.out_start    = out_start_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_burst_error_scheduler.sv
// Bench for burst_error_scheduler: table of frames with expected injection and
// flip counts, a reference model feeding a scoreboard, and hand-written corners.
module tb_burst_error_scheduler;
  import hamming_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_burst_len = '0;
  logic [7:0]  cfg_period = '0;
  logic        cfg_mode = 1'b0;
  logic [6:0]  cfg_start = '0;
  logic [15:0] frames_injected;
  out_state_e  dbg_state;

  burst_error_scheduler_if bus ();

  burst_error_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_we          (cfg_we),
    .cfg_burst_len   (cfg_burst_len),
    .cfg_period      (cfg_period),
    .cfg_mode        (cfg_mode),
    .cfg_start       (cfg_start),
    .bus             (bus.slave),
    .frames_injected (frames_injected),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [4:0]  m_len;
  logic [7:0]  m_period;
  bit          m_mode;
  logic [6:0]  m_start;
  int          m_since;
  logic [15:0] m_lfsr;

  logic [127:0] exp_q[$];
  logic [127:0] in_q[$];
  bit           exp_inj_q[$];
  logic [6:0]   exp_start_q[$];
  int           exp_flip_q[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic model_reset();
    m_len = '0; m_period = '0; m_mode = 0; m_start = '0; m_since = 0;
    m_lfsr = 16'hACE1;
    exp_q.delete(); in_q.delete(); exp_inj_q.delete();
    exp_start_q.delete(); exp_flip_q.delete();
  endtask

  task automatic model_accept(input logic [127:0] d, input bit tbl_inj, input int tbl_flips);
    bit           inj;
    int           le;
    logic [6:0]   st;
    logic [127:0] m;
    m_since++;
    inj = (m_period != 0) && ((m_since % int'(m_period)) == 0);
    le  = (int'(m_len) > 16) ? 16 : int'(m_len);
    st  = m_mode ? m_lfsr[6:0] : m_start;
    m   = (128'd1 << le) - 128'd1;
    m   = (m << st) | (m >> (128 - int'(st)));
    if (!inj) m = '0;
    if (inj) m_lfsr = lfsr_step(m_lfsr);
    exp_q.push_back(d ^ m);
    in_q.push_back(d);
    exp_inj_q.push_back(tbl_inj);
    exp_start_q.push_back(st);
    exp_flip_q.push_back(tbl_flips);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_frame(input logic [127:0] d, input bit tbl_inj, input int tbl_flips);
    bit ok;
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok) begin
        model_accept(d, tbl_inj, tbl_flips);
        done = 1;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: frame %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic do_cfg(input logic [4:0] len, input logic [7:0] per, input bit mode, input logic [6:0] st);
    cfg_we = 1'b1; cfg_burst_len = len; cfg_period = per; cfg_mode = mode; cfg_start = st;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_len = len; m_period = per; m_mode = mode; m_start = st; m_since = 0;
  endtask

  // Scoreboard: compare each output transfer against the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got %h with empty expected queue", bus.out_data);
      end else begin
        logic [127:0] e, din;
        bit           ei;
        logic [6:0]   es;
        int           ef;
        e = exp_q.pop_front(); din = in_q.pop_front(); ei = exp_inj_q.pop_front();
        es = exp_start_q.pop_front(); ef = exp_flip_q.pop_front();
        check("out_data", bus.out_data, e);
        check("out_injected", 128'(bus.out_injected), 128'(ei));
        check("flip_count", 128'($countones(bus.out_data ^ din)), 128'(ef));
        if (ei) check("out_start", 128'(bus.out_start), 128'(es));
      end
    end
  end

  typedef struct {
    bit           cfg;
    logic [4:0]   len;
    logic [7:0]   period;
    bit           mode;
    logic [6:0]   start;
    logic [127:0] data;
    bit           exp_inj;
    int           exp_flips;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit c, input logic [4:0] l, input logic [7:0] p, input bit md,
                     input logic [6:0] s, input logic [127:0] d, input bit ei, input int ef);
    vec_t v;
    v.cfg = c; v.len = l; v.period = p; v.mode = md; v.start = s;
    v.data = d; v.exp_inj = ei; v.exp_flips = ef;
    vecs.push_back(v);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ONES = {128{1'b1}};

  initial begin
    logic [15:0] lf;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    model_reset();

    add(0, 0, 0, 0, 0, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 0, 0);
    add(0, 0, 0, 0, 0, 128'h1234_5678_9abc_def0_1111_2222_3333_4444, 0, 0);
    add(0, 0, 0, 0, 0, 128'h1234_5678_dead_beef_cafe_f00d_0000_ffff, 0, 0);
    add(0, 0, 0, 0, 0, 128'h1234_0000_0000_0000_0000_0000_0000_0001, 0, 0);
    add(1, 4, 1, 0, 10,  '0, 1, 4);
    add(1, 4, 1, 0, 126, '0, 1, 4);
    add(1, 4, 3, 0, 0, ONES, 0, 0);
    add(0, 0, 0, 0, 0, ONES, 0, 0);
    add(0, 0, 0, 0, 0, ONES, 1, 4);
    add(0, 0, 0, 0, 0, ONES, 0, 0);
    add(0, 0, 0, 0, 0, ONES, 0, 0);
    add(0, 0, 0, 0, 0, ONES, 1, 4);
    add(1, 20, 1, 0, 50, ONES, 1, 16);
    add(1, 4, 0, 0, 10, ONES, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data", bus.out_data, 128'd0);
    check("rst_out_injected", 128'(bus.out_injected), 128'd0);
    check("rst_out_start", 128'(bus.out_start), 128'd0);
    check("rst_frames_injected", 128'(frames_injected), 128'd0);
    check("rst_state", 128'(dbg_state), 128'(OUT_EMPTY));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].cfg) do_cfg(vecs[i].len, vecs[i].period, vecs[i].mode, vecs[i].start);
      send_frame(vecs[i].data, vecs[i].exp_inj, vecs[i].exp_flips);
      if (i == 0) check("latency_1cycle", 128'(bus.out_valid), 128'd1);
      if (i == 4) begin
        drain();
        check("out_bits_10_13", bus.out_data, 128'h3c00);
        check("frames_injected_1", 128'(frames_injected), 128'd1);
      end
      if (i == 5) begin
        drain();
        check("out_wrap_126_1", bus.out_data, {2'b11, 122'd0, 4'b0011});
      end
    end
    drain();
    check("frames_injected_table", 128'(frames_injected), 128'd5);

    // Backpressure: output held, input stalled, nothing lost
    bus.out_ready = 1'b0;
    send_frame(128'hAAAA_0000_0000_0000_0000_0000_0000_5555, 0, 0);
    fork
      send_frame(128'hBBBB_0000_0000_0000_0000_0000_0000_6666, 0, 0);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("hold_in_ready", 128'(bus.in_ready), 128'd0);
          check("hold_out_valid", 128'(bus.out_valid), 128'd1);
          if (exp_q.size() != 0) check("hold_out_data", bus.out_data, exp_q[0]);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while a frame is held
    bus.out_ready = 1'b0;
    send_frame(128'hCCCC_0000_0000_0000_0000_0000_0000_7777, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("async_rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("async_rst_out_data", bus.out_data, 128'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_no_output", 128'(bus.out_valid), 128'd0);

    // LFSR start positions
    do_cfg(3, 1, 1, 0);
    send_frame('0, 1, 3);
    check("lfsr_first_start", 128'(bus.out_start), 128'h61);
    send_frame('0, 1, 3);
    lf = lfsr_step(16'hACE1);
    check("lfsr_second_start", 128'(bus.out_start), 128'(lf[6:0]));
    drain();
    check("frames_injected_lfsr", 128'(frames_injected), 128'd2);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
